// File: rtl/booth_operand_dispatcher.sv
// Issue stage for a multi-cycle booth multiplier: operand FIFO, one-op-at-a-time
// start/valid handshake, valid/ready product port with sequence tag. Optional
// watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module booth_operand_dispatcher #(
  parameter int W       = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  output logic           mul_start,
  output logic [W-1:0]   mul_x,
  output logic [W-1:0]   mul_y,
  input  logic           mul_valid,
  input  logic [2*W-1:0] mul_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_z,
  output logic [7:0]     out_seq,
  output logic           err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  // Async assert, synchronous release; everything else resets from rst_ni.
  logic [1:0] rst_sync_q;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ni = rst_sync_q[1];

  state_t                  state_q, state_d;
  logic [DEPTH-1:0][W-1:0] x_mem_q, x_mem_d, y_mem_q, y_mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic [W-1:0]            mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [2*W-1:0]          out_z_q, out_z_d;
  logic [7:0]              out_seq_q, out_seq_d, seq_q, seq_d;
  logic                    out_valid_q, out_valid_d;
  logic                    mul_valid_q, mul_valid_d;
  logic                    push, pop, done;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign in_ready  = rst_ni && (cnt_q < CNT_FULL);
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == IDLE) && (cnt_q != '0);
  // Only a fresh rising edge counts; a level left over from the last op is stale.
  assign done      = (state_q == WAIT) && mul_valid && !mul_valid_q;

  always_comb begin
    state_d     = state_q;
    x_mem_d     = x_mem_q;
    y_mem_d     = y_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    out_z_d     = out_z_q;
    out_seq_d   = out_seq_q;
    seq_d       = seq_q;
    out_valid_d = out_valid_q;
    mul_valid_d = mul_valid;
`ifdef DISPATCH_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
`endif

    if (push) begin
      x_mem_d[wr_ptr_q] = in_x;
      y_mem_d[wr_ptr_q] = in_y;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    unique case (state_q)
      IDLE: if (pop) begin
        mul_x_d = x_mem_q[rd_ptr_q];
        mul_y_d = y_mem_q[rd_ptr_q];
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef DISPATCH_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (done) begin
          out_z_d     = mul_z;
          out_seq_d   = seq_q;
          seq_d       = seq_q + 8'd1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
`ifdef DISPATCH_TIMEOUT_EN
        // The TIMEOUT-th WAIT cycle without completion drops the op and burns its tag.
        else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          seq_d   = seq_q + 8'd1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      x_mem_q     <= '0;
      y_mem_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      out_z_q     <= '0;
      out_seq_q   <= '0;
      seq_q       <= '0;
      out_valid_q <= 1'b0;
      mul_valid_q <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_mem_q     <= x_mem_d;
      y_mem_q     <= y_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      out_z_q     <= out_z_d;
      out_seq_q   <= out_seq_d;
      seq_q       <= seq_d;
      out_valid_q <= out_valid_d;
      mul_valid_q <= mul_valid_d;
`ifdef DISPATCH_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mul_start = (state_q == ISSUE);
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_seq   = out_seq_q;
`ifdef DISPATCH_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
